kmc_useq: RTL
=============

// Module: kmc_useq
//
// PURPOSE
//  KMC11 microsequencer. It drives the microcode address and fetches CRAM words
//  into an instruction register. It consumes the ALU carry and zero flags and
//  the BRG bits for conditional jumps.
//  Sits between the KMC CSR run/step logic, the CRAM and the KMC ALU. It
//  generates the one-cycle ALU clock enable that commits each microinstruction.
//
// PARAMETERS
//  AW     10      microcode address width (1K-word CRAM)
//  RSTPC  10'o0   MPC value after reset/kmcINIT
//
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-low
//  kmcINIT      in   1   synchronous initialize (same effect as rst)
//  kmcRUN       in   1   CSR run bit: free-run while high
//  kmcSTEP      in   1   one-clock pulse: execute one microinstruction while halted
//  kmcMPCLD     in   1   load MPC from kmcMPCIN (honoured only in HALT)
//  kmcMPCIN     in   AW  MPC load value
//  kmcSTALL     in   1   hold EXEC (NPR/memory busy)
//  kmcCRAMD     in   16  CRAM read data, valid 1 clk after kmcCRAMRD
//  kmcALUC      in   1   registered ALU carry
//  kmcALUZ      in   1   registered ALU zero
//  kmcBRG       in   8   BRG register
//  kmcBRKADDR   in   AW  breakpoint address (KMC_BRKPT_EN only)
//  kmcCRAMRD    out  1   CRAM read strobe
//  kmcMPC       out  AW  microprogram counter / CRAM address
//  kmcCRAM      out  16  instruction register (current microword)
//  kmcALUCLKEN  out  1   one-clock commit pulse to ALU/registers
//  kmcHALTED    out  1   sequencer in HALT
//  kmcBRKHIT    out  1   breakpoint halt flag (KMC_BRKPT_EN only, else 0)
//
// BEHAVIOUR
//  Reset (rst low, async) or kmcINIT (sync):
//   - state=HALT; kmcMPC=RSTPC; kmcCRAM=0; kmcCRAMRD=0; kmcALUCLKEN=0;
//     kmcHALTED=1; kmcBRKHIT=0.
//  States HALT, FETCH, LATCH, EXEC.
//  HALT:
//   - kmcMPCLD -> MPC<=kmcMPCIN.
//   - kmcRUN|kmcSTEP -> FETCH; a step is latched into stepflag.
//   - If both MPCLD and RUN/STEP: load first, then fetch the loaded address.
//  FETCH: kmcCRAMRD=1 for exactly 1 clk -> LATCH.
//  LATCH: IR<=kmcCRAMD -> EXEC.
//  EXEC:
//   - While kmcSTALL=1, hold EXEC with kmcALUCLKEN=0.
//   - First unstalled clk: kmcALUCLKEN=1 (exactly one clk); MPC<=next.
//   - Then FETCH if kmcRUN & !stepflag, else HALT (clear stepflag).
//  Latency: 3 clk per unstalled microinstruction.
//  Next-MPC rules:
//   - Non-jump word: MPC+1, wrapping 10'o1777 -> 10'o0.
//   - Jump word (`kmcCRAM_SRC == `kmcCRAM_SRC_JMP_*): cond=IR[10:8]:
//       0 always, 1 C, 2 Z, 3 !C, 4 !Z, 5 BRG[0], 6 BRG[7], 7 never.
//   - Taken: MPC<={IR[12:11],IR[7:0]}. Not taken: MPC+1.
//  Flags are sampled in the EXEC clk that asserts kmcALUCLKEN, i.e. the values
//  produced by the previous microinstruction.
//  kmcRUN falling mid-cycle: the current instruction completes, then HALT.
//  The sequencer never aborts between FETCH and commit.
//  kmcSTEP while not HALT: ignored. kmcMPCLD while not HALT: ignored.
//  kmcINIT has priority over all other inputs in the same clk.
//
// CONFIGURATION
//  KMC_BRKPT_EN defined:
//   - On entry to EXEC with MPC==kmcBRKADDR and kmcRUN=1 and !stepflag:
//     no commit (kmcALUCLKEN stays 0), kmcBRKHIT<=1, state->HALT, MPC unchanged.
//   - kmcBRKHIT clears on the next kmcRUN/kmcSTEP start.
//   - A step at the breakpoint address executes normally.
//  KMC_BRKPT_EN undefined: kmcBRKADDR ignored, kmcBRKHIT tied 0, no
//  comparator logic.
//
// TESTING
//  - rst low, then MPCLD 10'o100, STEP -> CRAMRD at clk+1, ALUCLKEN at clk+3,
//    MPC=10'o101, HALTED=1.
//  - RUN=1 from 10'o1777 with non-jump words -> MPC wraps to 10'o0, then
//    10'o1; ALUCLKEN every 3rd clk.
//  - Jump cond=1 target {2'b10,8'o25}: ALUC=1 -> MPC=10'o1025;
//    ALUC=0 -> MPC+1. Repeat Z/!C/!Z/BRG[0]/BRG[7]/never.
//  - kmcSTALL high 5 clk in EXEC -> ALUCLKEN delayed 5 clk, asserted once,
//    MPC advances once.
//  - RUN dropped in LATCH -> instruction commits, HALT; rst asserted
//    mid-EXEC -> immediate HALT, MPC=RSTPC, no ALUCLKEN.
//  - KMC_BRKPT_EN, BRKADDR=10'o5, RUN from 0 -> 5 commits (0-4), BRKHIT=1,
//    MPC=5; STEP -> executes 5, MPC=6, BRKHIT=0.

Source files
------------

// File: rtl/kmc_useq.sv
// KMC11 microsequencer: HALT/FETCH/LATCH/EXEC loop driving the CRAM address and committing microwords.
// Optional breakpoint halt enabled by defining KMC_BRKPT_EN. Jump words carry source field IR[15:14] == 2'b11.
module kmc_useq #(
    parameter int unsigned   AW    = 10,
    parameter logic [AW-1:0] RSTPC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kmcINIT,
    input  logic          kmcRUN,
    input  logic          kmcSTEP,
    input  logic          kmcMPCLD,
    input  logic [AW-1:0] kmcMPCIN,
    input  logic          kmcSTALL,
    input  logic [15:0]   kmcCRAMD,
    input  logic          kmcALUC,
    input  logic          kmcALUZ,
    input  logic [7:0]    kmcBRG,
    input  logic [AW-1:0] kmcBRKADDR,
    output logic          kmcCRAMRD,
    output logic [AW-1:0] kmcMPC,
    output logic [15:0]   kmcCRAM,
    output logic          kmcALUCLKEN,
    output logic          kmcHALTED,
    output logic          kmcBRKHIT
);

    localparam int unsigned IRW     = 16;
    localparam logic [1:0]  SRC_JMP = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  mpc_q, mpc_d;
    logic [IRW-1:0] ir_q, ir_d;
    logic           cramrd_q, cramrd_d;
    logic           halted_q, halted_d;
    logic           step_q, step_d;
    logic           brkhit_q, brkhit_d;

    logic           cond_c;
    logic           jump_c;
    logic [AW-1:0]  next_mpc_c;
    logic           brk_c;
    logic           aluclken_c;

    // Branch condition select; flags are those left by the previous microword
    always_comb begin
        cond_c = 1'b0;
        unique case (ir_q[10:8])
            3'd0: cond_c = 1'b1;
            3'd1: cond_c = kmcALUC;
            3'd2: cond_c = kmcALUZ;
            3'd3: cond_c = !kmcALUC;
            3'd4: cond_c = !kmcALUZ;
            3'd5: cond_c = kmcBRG[0];
            3'd6: cond_c = kmcBRG[7];
            3'd7: cond_c = 1'b0;
        endcase
    end

    assign jump_c     = (ir_q[15:14] == SRC_JMP);
    assign next_mpc_c = (jump_c && cond_c) ? AW'({ir_q[12:11], ir_q[7:0]})
                                           : mpc_q + AW'(1);

`ifdef KMC_BRKPT_EN
    assign brk_c = (state_q == ST_EXEC) && (mpc_q == kmcBRKADDR) && kmcRUN && !step_q;
`else
    logic unused_brkaddr_c;
    assign unused_brkaddr_c = ^kmcBRKADDR;
    assign brk_c            = 1'b0;
`endif

    // Commit strobe is live during the unstalled EXEC cycle so the ALU and MPC update on the same edge
    assign aluclken_c = (state_q == ST_EXEC) && !kmcSTALL && !brk_c && !kmcINIT;

    always_comb begin
        state_d  = state_q;
        mpc_d    = mpc_q;
        ir_d     = ir_q;
        cramrd_d = 1'b0;
        halted_d = halted_q;
        step_d   = step_q;
        brkhit_d = brkhit_q;

        unique case (state_q)
            ST_HALT: begin
                if (kmcMPCLD) begin
                    mpc_d = kmcMPCIN;
                end
                if (kmcRUN || kmcSTEP) begin
                    state_d  = ST_FETCH;
                    cramrd_d = 1'b1;
                    halted_d = 1'b0;
                    step_d   = kmcSTEP;
                    brkhit_d = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ir_d    = kmcCRAMD;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (brk_c) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    brkhit_d = 1'b1;
                    step_d   = 1'b0;
                end else if (!kmcSTALL) begin
                    mpc_d = next_mpc_c;
                    if (kmcRUN && !step_q) begin
                        state_d  = ST_FETCH;
                        cramrd_d = 1'b1;
                    end else begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        step_d   = 1'b0;
                    end
                end
            end
        endcase

        // Synchronous initialize overrides everything above
        if (kmcINIT) begin
            state_d  = ST_HALT;
            mpc_d    = RSTPC;
            ir_d     = '0;
            cramrd_d = 1'b0;
            halted_d = 1'b1;
            step_d   = 1'b0;
            brkhit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HALT;
            mpc_q    <= RSTPC;
            ir_q     <= '0;
            cramrd_q <= 1'b0;
            halted_q <= 1'b1;
            step_q   <= 1'b0;
            brkhit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mpc_q    <= mpc_d;
            ir_q     <= ir_d;
            cramrd_q <= cramrd_d;
            halted_q <= halted_d;
            step_q   <= step_d;
            brkhit_q <= brkhit_d;
        end
    end

    assign kmcCRAMRD   = cramrd_q;
    assign kmcMPC      = mpc_q;
    assign kmcCRAM     = ir_q;
    assign kmcALUCLKEN = aluclken_c;
    assign kmcHALTED   = halted_q;
    assign kmcBRKHIT   = brkhit_q;

endmodule
